morse_symbol_decoder: RTL and testbench
=======================================

# morse_symbol_decoder

Parametrised Morse key decoder. It times the mark and space intervals of a synchronous key input `b` in programmable "units" and classifies each mark as a dot or a dash. It classifies each space as an intra-letter gap, a letter gap or a word gap, and packs the decoded symbols of each letter into a code word. It sits between the key input conditioning and the character lookup/display logic, and replaces the fixed-threshold decoder FSM plus its external timer and counter.

## Interface
- `UNIT_TICKS`, 10: enabled ticks per Morse unit (≥2).
- `DASH_UNITS`, 2: mark length in units at or above which a mark is a dash.
- `LGAP_UNITS`, 3: space length in units that ends a letter.
- `WGAP_UNITS`, 7: space length in units that ends a word (> `LGAP_UNITS`).
- `MAX_SYM`, 5: maximum symbols per letter.
- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, asynchronous, active-low. Reset `reset_n` is asynchronous, active-low; clock is `clk`.
- `tick_en`, input, 1: timebase enable; timers advance only when it is high.
- `b`, input, 1: key level, 1 = mark.
- `dot`, output, 1: one-cycle pulse, dot classified.
- `dash`, output, 1: one-cycle pulse, dash classified.
- `lg`, output, 1: one-cycle pulse, letter gap.
- `wg`, output, 1: one-cycle pulse, word gap.
- `char_valid`, output, 1: one-cycle pulse, letter complete; coincides with `lg`.
- `char_code`, output, `MAX_SYM`: bit i = symbol i (1 = dash, 0 = dot), first symbol in bit 0, unused bits 0.
- `char_len`, output, `$clog2(MAX_SYM+1)`: symbol count of the letter.
- `char_err`, output, 1: letter overflowed `MAX_SYM` symbols.

## Operation
- States: IDLE, MARK, SPACE, LGAP.
- Timer: `tick_cnt` counts `tick_en` cycles from 0 to `UNIT_TICKS-1` and wraps. Each wrap increments `unit_cnt`, which saturates at `WGAP_UNITS`. Both counters clear on every state change.
- IDLE: `b`=1 goes to MARK. `b`=0 stays in IDLE, with the timer held at 0.
- MARK, on `b`=0, the mark is classified by `unit_cnt`:
  - 0: glitch. No pulse. Return to SPACE if `char_len_acc`>0, otherwise IDLE.
  - 1 to `DASH_UNITS`-1: `dot`.
  - ≥`DASH_UNITS`: `dash`.
  - After a dot or dash, go to SPACE.
- SPACE: `b`=1 goes to MARK (same letter). When `unit_cnt` reaches `LGAP_UNITS`, pulse `lg` and go to LGAP. `char_valid` pulses together with `lg` only if the accumulator holds at least one symbol.
- LGAP: `b`=1 goes to MARK (new letter). When `unit_cnt` reaches `WGAP_UNITS-LGAP_UNITS`, pulse `wg` and go to IDLE. Because of this, `wg` always follows `lg` of the same space, exactly `(WGAP_UNITS-LGAP_UNITS)*UNIT_TICKS` enabled ticks later.
- Accumulator, on each dot/dash:
  - If `len_acc`<`MAX_SYM`: `code_acc[len_acc]` ← is_dash and `len_acc`++.
  - Otherwise set the sticky `err_acc` and drop the symbol.
  - On `char_valid`: copy `code_acc`/`len_acc`/`err_acc` to `char_code`/`char_len`/`char_err` and clear the accumulator.
  - The `char_*` outputs hold their value until the next `char_valid`.
- `tick_en` low freezes both counters. Key edges are still acted on.

## Timing
- All outputs are registered. A pulse appears in the cycle after the `clk` edge at which the causing condition (release of `b`, or the unit wrap) was sampled.
- All pulses are exactly 1 cycle wide. `dot`/`dash` are never coincident with `lg`/`wg`.
- Reset values: all outputs 0, state IDLE, counters and accumulator 0.
- Reset asserted mid-operation discards any partial letter. No pulse is emitted on reset exit. If `b` is high at reset release, MARK is entered on the first edge.

## Configuration
- `MORSE_DEGLITCH_EN` defined:
  - `b` passes through a 2-flop synchronizer, then a filter that accepts a new level only after 4 consecutive identical `clk` samples.
  - This adds 6 cycles of latency to every key edge, and pulses shorter than 4 cycles are invisible.
- Not defined: `b` is used directly and must already be synchronous to `clk`. There is no added latency.

## Test plan
All cases use `UNIT_TICKS`=4, `tick_en`=1, defaults otherwise, macro off.
- `b` high 6 cycles then low 14 cycles:
  - `dot` pulse.
  - 12 cycles after the release, `lg` and `char_valid` with `char_code`=5'b00000, `char_len`=1, `char_err`=0 ("E").
- Marks of 10, 5 and 10 cycles separated by 5-cycle spaces, then 13 cycles low:
  - `dash`, `dot`, `dash`.
  - Then `char_valid` with `char_code`=5'b00101, `char_len`=3 ("K").
- Six 5-cycle dots with 5-cycle spaces, then a letter gap:
  - `char_valid` with `char_len`=5, `char_code`=0, `char_err`=1.
  - The next letter has `char_err`=0.
- One dot, then `b` low 40 cycles:
  - `lg` pulses, and `wg` pulses exactly 16 cycles later.
  - The decoder is then in IDLE, with no further pulses while `b` stays low.
- `b` high 2 cycles (glitch): no pulses.
- `reset_n` asserted during a dash, then released: all outputs 0 and no pulses until new key activity.
- `tick_en` held low for 20 cycles inside a mark: the mark classification is unchanged by the frozen interval.

Source files
------------

// File: rtl/morse_symbol_decoder.sv
// -----------------------------------------------------------------------------
// morse_symbol_decoder
//
// Times the mark and space intervals of a synchronous Morse key input in
// programmable units. Each mark is classified as a dot or a dash. Each space is
// classified as an intra-letter gap, a letter gap or a word gap. The symbols of
// one letter are packed into a code word that is presented when the letter
// completes.
//
// Optional feature macro: MORSE_DEGLITCH_EN
//   defined   : b -> 2-flop synchronizer -> 4-sample level filter
//               (6 cycles of added latency)
//   undefined : b is used directly and must already be synchronous to clk
//
// Ports
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   tick_en     in   timebase enable; the interval timers advance only when high
//   b           in   key level, 1 = mark
//   dot         out  1-cycle pulse, dot classified
//   dash        out  1-cycle pulse, dash classified
//   lg          out  1-cycle pulse, letter gap
//   wg          out  1-cycle pulse, word gap
//   char_valid  out  1-cycle pulse, letter complete (coincides with lg)
//   char_code   out  bit i = symbol i (1 = dash), first symbol in bit 0
//   char_len    out  symbol count of the letter
//   char_err    out  letter overflowed MAX_SYM symbols
// -----------------------------------------------------------------------------
module morse_symbol_decoder #(
    parameter int UNIT_TICKS = 10,
    parameter int DASH_UNITS = 2,
    parameter int LGAP_UNITS = 3,
    parameter int WGAP_UNITS = 7,
    parameter int MAX_SYM    = 5
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             tick_en,
    input  logic                             b,
    output logic                             dot,
    output logic                             dash,
    output logic                             lg,
    output logic                             wg,
    output logic                             char_valid,
    output logic [MAX_SYM-1:0]               char_code,
    output logic [$clog2(MAX_SYM+1)-1:0]     char_len,
    output logic                             char_err
);

    localparam int LEN_W  = $clog2(MAX_SYM + 1);
    localparam int UNIT_W = $clog2(WGAP_UNITS + 1);
    localparam int TICK_W = $clog2(UNIT_TICKS);

    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);
    localparam logic [UNIT_W-1:0] UNIT_ZERO = UNIT_W'(0);
    localparam logic [UNIT_W-1:0] DASH_U    = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] LGAP_U    = UNIT_W'(LGAP_UNITS);
    localparam logic [UNIT_W-1:0] WGAP_U    = UNIT_W'(WGAP_UNITS);
    // The LGAP state restarts the timer, so the word gap fires after the remainder.
    localparam logic [UNIT_W-1:0] WREST_U   = UNIT_W'(WGAP_UNITS - LGAP_UNITS);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = LEN_W'(0);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_SYM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_LGAP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [UNIT_W-1:0]   r_unit_cnt;
    logic [UNIT_W-1:0]   w_unit_inc;
    logic                w_wrap;
    logic                w_key;
    logic                w_dot_nxt;
    logic                w_dash_nxt;
    logic                w_lg_nxt;
    logic                w_wg_nxt;
    logic                w_cv_nxt;
    logic [MAX_SYM-1:0]  r_code_acc;
    logic [LEN_W-1:0]    r_len_acc;
    logic                r_err_acc;
    logic                r_dot;
    logic                r_dash;
    logic                r_lg;
    logic                r_wg;
    logic                r_cv;
    logic [MAX_SYM-1:0]  r_char_code;
    logic [LEN_W-1:0]    r_char_len;
    logic                r_char_err;

`ifdef MORSE_DEGLITCH_EN
    logic       r_sync1;
    logic       r_sync2;
    logic [2:0] r_hist;
    logic       r_filt;

    // Synchronize the key and accept a new level only after 4 identical samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 3'b000;
            r_filt  <= 1'b0;
        end else begin
            r_sync1 <= b;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[1:0], r_sync2};
            if (r_hist == {3{r_sync2}}) begin
                r_filt <= r_sync2;
            end else begin
                r_filt <= r_filt;
            end
        end
    end

    assign w_key = r_filt;
`else
    assign w_key = b;
`endif

    // Timer helpers: end-of-unit strobe and saturating unit increment.
    always_comb begin
        w_wrap     = tick_en && (r_tick_cnt == TICK_LAST);
        w_unit_inc = r_unit_cnt;
        if (r_unit_cnt >= WGAP_U) begin
            w_unit_inc = r_unit_cnt;
        end else begin
            w_unit_inc = r_unit_cnt + UNIT_W'(1);
        end
    end

    // Next-state and pulse decode; space thresholds act on the wrap that reaches them.
    always_comb begin
        w_state_nxt = r_state;
        w_dot_nxt   = 1'b0;
        w_dash_nxt  = 1'b0;
        w_lg_nxt    = 1'b0;
        w_wg_nxt    = 1'b0;
        w_cv_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_key) begin
                    w_state_nxt = S_MARK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MARK: begin
                if (!w_key) begin
                    if (r_unit_cnt == UNIT_ZERO) begin
                        // Glitch: resume the pending letter if there is one.
                        if (r_len_acc != LEN_ZERO) begin
                            w_state_nxt = S_SPACE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (r_unit_cnt < DASH_U) begin
                        w_dot_nxt   = 1'b1;
                        w_state_nxt = S_SPACE;
                    end else begin
                        w_dash_nxt  = 1'b1;
                        w_state_nxt = S_SPACE;
                    end
                end else begin
                    w_state_nxt = S_MARK;
                end
            end
            S_SPACE: begin
                if (w_key) begin
                    w_state_nxt = S_MARK;
                end else if (w_wrap && (w_unit_inc == LGAP_U)) begin
                    w_lg_nxt    = 1'b1;
                    w_cv_nxt    = (r_len_acc != LEN_ZERO);
                    w_state_nxt = S_LGAP;
                end else begin
                    w_state_nxt = S_SPACE;
                end
            end
            S_LGAP: begin
                if (w_key) begin
                    w_state_nxt = S_MARK;
                end else if (w_wrap && (w_unit_inc == WREST_U)) begin
                    w_wg_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LGAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Interval timer: held at zero in IDLE, cleared on every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= TICK_ZERO;
            r_unit_cnt <= UNIT_ZERO;
        end else if ((r_state == S_IDLE) || (w_state_nxt != r_state)) begin
            r_tick_cnt <= TICK_ZERO;
            r_unit_cnt <= UNIT_ZERO;
        end else if (w_wrap) begin
            r_tick_cnt <= TICK_ZERO;
            r_unit_cnt <= w_unit_inc;
        end else if (tick_en) begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            r_unit_cnt <= r_unit_cnt;
        end else begin
            r_tick_cnt <= r_tick_cnt;
            r_unit_cnt <= r_unit_cnt;
        end
    end

    // Letter accumulator and presented character; overflow symbols are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code_acc  <= {MAX_SYM{1'b0}};
            r_len_acc   <= LEN_ZERO;
            r_err_acc   <= 1'b0;
            r_char_code <= {MAX_SYM{1'b0}};
            r_char_len  <= LEN_ZERO;
            r_char_err  <= 1'b0;
        end else if (w_cv_nxt) begin
            r_char_code <= r_code_acc;
            r_char_len  <= r_len_acc;
            r_char_err  <= r_err_acc;
            r_code_acc  <= {MAX_SYM{1'b0}};
            r_len_acc   <= LEN_ZERO;
            r_err_acc   <= 1'b0;
        end else if (w_dot_nxt || w_dash_nxt) begin
            if (r_len_acc < LEN_MAX) begin
                for (int i = 0; i < MAX_SYM; i++) begin
                    if (LEN_W'(i) == r_len_acc) begin
                        r_code_acc[i] <= w_dash_nxt;
                    end else begin
                        r_code_acc[i] <= r_code_acc[i];
                    end
                end
                r_len_acc <= r_len_acc + LEN_W'(1);
            end else begin
                r_err_acc <= 1'b1;
            end
        end else begin
            r_code_acc <= r_code_acc;
            r_len_acc  <= r_len_acc;
            r_err_acc  <= r_err_acc;
        end
    end

    // One-cycle output pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dot  <= 1'b0;
            r_dash <= 1'b0;
            r_lg   <= 1'b0;
            r_wg   <= 1'b0;
            r_cv   <= 1'b0;
        end else begin
            r_dot  <= w_dot_nxt;
            r_dash <= w_dash_nxt;
            r_lg   <= w_lg_nxt;
            r_wg   <= w_wg_nxt;
            r_cv   <= w_cv_nxt;
        end
    end

    assign dot        = r_dot;
    assign dash       = r_dash;
    assign lg         = r_lg;
    assign wg         = r_wg;
    assign char_valid = r_cv;
    assign char_code  = r_char_code;
    assign char_len   = r_char_len;
    assign char_err   = r_char_err;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_symbol_decoder
//
// Scoreboard bench: each key-stimulus task pushes the pulses it must cause
// (mask, edge number, character fields) and a negedge monitor pops and compares
// every pulse the decoder produces. UNIT_TICKS = 4, other parameters default.
// -----------------------------------------------------------------------------
module tb_morse_symbol_decoder;

    localparam int UT    = 4;
    localparam int DASHU = 2;
    localparam int LGU   = 3;
    localparam int WGU   = 7;
    localparam int MS    = 5;

    // mask bits: {char_valid, wg, lg, dash, dot}
    typedef struct packed {
        logic [4:0] mask;
        int         cyc;
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_en = 1'b1;
    logic       b       = 1'b0;
    logic       dot, dash, lg, wg, char_valid, char_err;
    logic [4:0] char_code;
    logic [2:0] char_len;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic [4:0] m_code;
    int         m_len;
    logic       m_err;

    morse_symbol_decoder #(
        .UNIT_TICKS(UT),
        .DASH_UNITS(DASHU),
        .LGAP_UNITS(LGU),
        .WGAP_UNITS(WGU),
        .MAX_SYM(MS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick_en(tick_en),
        .b(b),
        .dot(dot),
        .dash(dash),
        .lg(lg),
        .wg(wg),
        .char_valid(char_valid),
        .char_code(char_code),
        .char_len(char_len),
        .char_err(char_err)
    );

    always #5 clk = ~clk;

    // Edge counter: value k at a negedge means outputs from posedge k are visible.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [4:0] obs;
        exp_t       e;
        obs = {char_valid, wg, lg, dash, dot};
        if (obs != 5'd0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got mask=%b at edge %0d, expected no pulse", obs, cyc);
            end else begin
                e = q.pop_front();
                if (obs !== e.mask || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL pulse: got mask=%b at edge %0d, expected mask=%b at edge %0d",
                             obs, cyc, e.mask, e.cyc);
                end
                if (e.mask[4]) begin
                    checks++;
                    if ({char_code, char_len, char_err} !== {e.code, e.len, e.err}) begin
                        errors++;
                        $display("FAIL char: got code=%b len=%0d err=%b, expected code=%b len=%0d err=%b",
                                 char_code, char_len, char_err, e.code, e.len, e.err);
                    end
                end
            end
        end
    end

    function automatic void model_clear();
        m_code = 5'd0;
        m_len  = 0;
        m_err  = 1'b0;
    endfunction

    function automatic void push(input logic [4:0] mask, input int at);
        exp_t e;
        e.mask = mask;
        e.cyc  = at;
        e.code = m_code;
        e.len  = 3'(m_len);
        e.err  = m_err;
        q.push_back(e);
    endfunction

    function automatic void model_sym(input logic is_dash);
        if (m_len < MS) begin
            m_code[m_len] = is_dash;
            m_len++;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    // Mark sampled high on n edges; release is sampled on edge s+n.
    task automatic key_mark(input int n);
        int s;
        int units;
        s     = cyc + 1;
        units = (n - 1) / UT;
        if (units >= DASHU) begin
            push(5'b00010, s + n);
            model_sym(1'b1);
        end else if (units >= 1) begin
            push(5'b00001, s + n);
            model_sym(1'b0);
        end
        b = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Mark with tick_en held low for nf edges in the middle.
    task automatic key_mark_frozen(input int n1, input int nf, input int n2);
        int s;
        int units;
        s     = cyc + 1;
        units = (n1 - 1 + n2) / UT;
        if (units >= DASHU) begin
            push(5'b00010, s + n1 + nf + n2);
            model_sym(1'b1);
        end else if (units >= 1) begin
            push(5'b00001, s + n1 + nf + n2);
            model_sym(1'b0);
        end
        b = 1'b1;
        repeat (n1) @(negedge clk);
        tick_en = 1'b0;
        repeat (nf) @(negedge clk);
        tick_en = 1'b1;
        repeat (n2) @(negedge clk);
    endtask

    // Space following a symbol; s is the edge that samples the release.
    task automatic key_space(input int n);
        int s;
        s = cyc + 1;
        if ((m_len > 0) && (n >= LGU * UT + 1)) begin
            push(5'b10100, s + LGU * UT);
            model_clear();
            if (n >= WGU * UT + 1) begin
                push(5'b01000, s + WGU * UT);
            end
        end
        b = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d expected pulses never seen, expected 0 outstanding", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({dot, dash, lg, wg, char_valid} !== 5'd0) begin
            errors++;
            $display("FAIL %s_pulses: got %b expected 00000", name, {dot, dash, lg, wg, char_valid});
        end
        checks++;
        if ({char_code, char_len, char_err} !== 9'd0) begin
            errors++;
            $display("FAIL %s_char: got code=%b len=%0d err=%b expected all 0", name, char_code, char_len, char_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        b       = 1'b0;
        tick_en = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_exit");
    endtask

    task automatic test_letter_e();
        key_mark(6);
        key_space(14);
        drain("letter_e");
    endtask

    task automatic test_letter_k();
        key_mark(10);
        key_space(5);
        key_mark(5);
        key_space(5);
        key_mark(10);
        key_space(13);
        drain("letter_k");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            key_mark(5);
            key_space(5);
        end
        key_mark(5);
        key_space(13);
        key_mark(5);
        key_space(13);
        drain("overflow");
    endtask

    task automatic test_word_gap();
        key_mark(6);
        key_space(40);
        drain("word_gap");
    endtask

    task automatic test_glitch();
        key_mark(2);
        key_space(20);
        drain("glitch");
    endtask

    task automatic test_reset_mid_dash();
        key_mark(5);
        key_space(5);
        b = 1'b1;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        b       = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_outputs_zero("mid_reset");
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check_outputs_zero("mid_reset_quiet");
        key_mark(6);
        key_space(14);
        drain("after_reset");
    endtask

    task automatic test_tick_freeze();
        key_mark_frozen(3, 20, 2);
        key_space(14);
        drain("tick_freeze");
    endtask

    task automatic test_back_to_back();
        key_mark(10);
        key_space(13);
        key_mark(6);
        key_space(5);
        key_mark(10);
        key_space(30);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_letter_k();
        test_overflow();
        test_word_gap();
        test_glitch();
        test_reset_mid_dash();
        test_tick_freeze();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
